// File: rtl/med_pkg.sv
// med_pkg: shared types and defaults for the rank-order filter.
package med_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SORT, OUT} state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_SIZE = 9;
  localparam int MED_RANK_DEF = (DEF_SIZE - 1) / 2;
  typedef logic [DEF_WIDTH-1:0] sample_t;
endpackage

// File: rtl/med_cmp.sv
// med_cmp: combinational unsigned compare-exchange.
module med_cmp #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  assign hi = a >= b ? a : b;
  assign lo = a >= b ? b : a;
endmodule

// File: rtl/med_rank.sv
// med_rank: serial rank-order filter returning the sample of a selectable rank from a SIZE window.
module med_rank
  import med_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SIZE = 9,
  parameter int RW = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RW-1:0]    rank,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int CW = $clog2(SIZE + 1);
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);
  state_t st;
  logic [WIDTH-1:0] w [SIZE];
  logic [WIDTH-1:0] hi, lo;
  logic [CW-1:0] cyc, pass, p, rsat;
  logic hs, last;
  assign hs = in_valid & in_ready;
  assign last = cyc == LAST;
  assign rsat = CW'(rank) > LAST ? LAST : CW'(rank);
  med_cmp #(.WIDTH(WIDTH)) u_cmp (.a(w[SIZE-1]), .b(w[SIZE-2]), .hi(hi), .lo(lo));
  // Tail keeps the running maximum while the rest rotates; on the last cycle of a
  // pass the winner is dropped and a zero takes its place, so the next pass finds the next-largest.
  always_ff @(posedge clk) begin
    if (st == SORT) begin
      w[SIZE-1] <= last ? w[SIZE-2] : hi;
      w[0] <= last ? '0 : lo;
    end else if (hs) begin
      w[SIZE-1] <= w[SIZE-2];
      w[0] <= in_data;
    end
    if (st == SORT || hs)
      for (int i = 1; i < SIZE - 1; i++) w[i] <= w[i-1];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      cyc <= '0;
      pass <= '0;
      p <= '0;
    end else begin
      case (st)
        IDLE: begin
          in_ready <= 1'b1;
          if (hs) begin
            p <= CW'(SIZE) - rsat;
            cyc <= CW'(1);
            st <= LOAD;
          end
        end
        LOAD: if (hs) begin
          cyc <= last ? '0 : cyc + 1'b1;
          pass <= '0;
          if (last) begin
            in_ready <= 1'b0;
            st <= SORT;
          end
        end
        SORT: begin
          cyc <= last ? '0 : cyc + 1'b1;
          if (last && pass == p - 1'b1) begin
            out_data <= w[SIZE-1];
            out_valid <= 1'b1;
            st <= OUT;
          end else if (last) pass <= pass + 1'b1;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          st <= IDLE;
        end
      endcase
    end
  end
endmodule
